// File: rtl/sha2_pkg.sv
// Shared SHA-2 definitions: sha_type encoding, round counts and the message-schedule state enum.
package sha2_pkg;

    localparam int SHA_TUSER_OFFSET = 32;
    localparam int ROUNDS_256       = 64;
    localparam int ROUNDS_512       = 80;
    localparam int BLOCK_WORDS      = 16;

    typedef enum logic [1:0] {
        SHA_224 = 2'b00,
        SHA_256 = 2'b01,
        SHA_384 = 2'b10,
        SHA_512 = 2'b11
    } sha_type_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOAD   = 2'b01,
        ST_EXPAND = 2'b10
    } state_t;

    function automatic logic is_mode64(input sha_type_t sha_type);
        return sha_type[1];
    endfunction

endpackage

// File: rtl/sched_sigma.sv
// Combinational SHA-2 small sigma; SIGMA1 selects sigma1 over sigma0, mode64 selects the 64-bit variant.
module sched_sigma #(
    parameter bit SIGMA1 = 1'b0
) (
    input  logic [63:0] x,
    input  logic        mode64,
    output logic [63:0] y
);

    function automatic logic [31:0] rotr32(input logic [31:0] v, input int unsigned n);
        return (v >> n) | (v << (32'd32 - n));
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] v, input int unsigned n);
        return (v >> n) | (v << (32'd64 - n));
    endfunction

    logic [31:0] x32_s;
    logic [31:0] s32_s;
    logic [63:0] s64_s;

    // Select the sigma variant and zero the upper half in 32-bit mode
    always_comb begin
        x32_s = x[31:0];
        if (SIGMA1) begin
            s32_s = rotr32(x32_s, 32'd17) ^ rotr32(x32_s, 32'd19) ^ (x32_s >> 10);
            s64_s = rotr64(x, 32'd19) ^ rotr64(x, 32'd61) ^ (x >> 6);
        end else begin
            s32_s = rotr32(x32_s, 32'd7) ^ rotr32(x32_s, 32'd18) ^ (x32_s >> 3);
            s64_s = rotr64(x, 32'd1) ^ rotr64(x, 32'd8) ^ (x >> 7);
        end
        if (mode64) begin
            y = s64_s;
        end else begin
            y = {32'd0, s32_s};
        end
    end

endmodule

// File: rtl/msg_schedule.sv
// SHA-2 message schedule: passes 16 words per block, then expands to 64/80 W_t beats on AXI-Stream.
// Optional sticky protocol checker enabled by MSG_SCHEDULE_PROTOCOL_CHECK_EN.
module msg_schedule
    import sha2_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 64,
    parameter int C_M_AXIS_DATA_WIDTH  = 64,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int SHA_TUSER_OFFSET     = 32
) (
    input  logic                            axis_aclk,
    input  logic                            reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]  m_axis_tdata,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic                            err
);

    state_t                          state_r, state_nxt_s;
    logic [6:0]                      t_r, t_nxt_s;
    logic                            mode64_r, mode64_nxt_s;
    logic                            blk_last_r, blk_last_nxt_s;
    logic [63:0]                     tdata_r, tdata_nxt_s;
    logic [C_M_AXIS_TUSER_WIDTH-1:0] tuser_r, tuser_nxt_s;
    logic                            tvalid_r, tvalid_nxt_s;
    logic                            tlast_r, tlast_nxt_s;
    logic [15:0][63:0]               window_r;
    logic                            push_s;
    logic [63:0]                     push_word_s;
    logic                            tready_s;
    logic                            slot_free_s;
    logic                            in_hs_s;
    logic [63:0]                     in_raw_s, in_word_s;
    logic [63:0]                     sig0_s, sig1_s, w_sum_s, w_new_s;
    logic [6:0]                      last_round_s;

    assign slot_free_s  = ~tvalid_r | m_axis_tready;
    assign in_hs_s      = (state_r == ST_LOAD) & s_axis_tvalid & slot_free_s;
    assign last_round_s = mode64_r ? 7'(ROUNDS_512 - 1) : 7'(ROUNDS_256 - 1);
    assign in_raw_s     = 64'(s_axis_tdata);
    assign in_word_s    = mode64_r ? in_raw_s : {32'd0, in_raw_s[31:0]};

    // window_r[0] is W[t-16], window_r[15] is W[t-1]
    sched_sigma #(.SIGMA1(1'b0)) u_sigma0 (.x(window_r[1]),  .mode64(mode64_r), .y(sig0_s));
    sched_sigma #(.SIGMA1(1'b1)) u_sigma1 (.x(window_r[14]), .mode64(mode64_r), .y(sig1_s));

    assign w_sum_s = sig1_s + window_r[9] + sig0_s + window_r[0];
    assign w_new_s = mode64_r ? w_sum_s : {32'd0, w_sum_s[31:0]};

    // Next-state, output slot and window push decisions
    always_comb begin
        state_nxt_s    = state_r;
        t_nxt_s        = t_r;
        mode64_nxt_s   = mode64_r;
        blk_last_nxt_s = blk_last_r;
        tdata_nxt_s    = tdata_r;
        tuser_nxt_s    = tuser_r;
        tvalid_nxt_s   = tvalid_r;
        tlast_nxt_s    = tlast_r;
        push_s         = 1'b0;
        push_word_s    = 64'd0;
        tready_s       = 1'b0;

        // A freed slot empties unless this cycle refills it below
        if (slot_free_s) begin
            tvalid_nxt_s = 1'b0;
            tlast_nxt_s  = 1'b0;
        end else begin
            tvalid_nxt_s = tvalid_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (s_axis_tvalid) begin
                    mode64_nxt_s = is_mode64(sha_type_t'(s_axis_tuser[SHA_TUSER_OFFSET +: 2]));
                    tuser_nxt_s  = C_M_AXIS_TUSER_WIDTH'(s_axis_tuser);
                    t_nxt_s      = 7'd0;
                    state_nxt_s  = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                tready_s = slot_free_s;
                if (in_hs_s) begin
                    push_s       = 1'b1;
                    push_word_s  = in_word_s;
                    tdata_nxt_s  = in_word_s;
                    tvalid_nxt_s = 1'b1;
                    tlast_nxt_s  = 1'b0;
                    if (t_r == 7'(BLOCK_WORDS - 1)) begin
                        blk_last_nxt_s = s_axis_tlast;
                        state_nxt_s    = ST_EXPAND;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                    t_nxt_s = t_r + 7'd1;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_EXPAND: begin
                if (slot_free_s) begin
                    push_s       = 1'b1;
                    push_word_s  = w_new_s;
                    tdata_nxt_s  = w_new_s;
                    tvalid_nxt_s = 1'b1;
                    if (t_r == last_round_s) begin
                        tlast_nxt_s = blk_last_r;
                        t_nxt_s     = 7'd0;
                        state_nxt_s = blk_last_r ? ST_IDLE : ST_LOAD;
                    end else begin
                        tlast_nxt_s = 1'b0;
                        t_nxt_s     = t_r + 7'd1;
                    end
                end else begin
                    state_nxt_s = ST_EXPAND;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Control and output slot registers
    always_ff @(posedge axis_aclk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            t_r        <= 7'd0;
            mode64_r   <= 1'b0;
            blk_last_r <= 1'b0;
            tdata_r    <= 64'd0;
            tuser_r    <= '0;
            tvalid_r   <= 1'b0;
            tlast_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            t_r        <= t_nxt_s;
            mode64_r   <= mode64_nxt_s;
            blk_last_r <= blk_last_nxt_s;
            tdata_r    <= tdata_nxt_s;
            tuser_r    <= tuser_nxt_s;
            tvalid_r   <= tvalid_nxt_s;
            tlast_r    <= tlast_nxt_s;
        end
    end

    // Sliding 16-word window, newest word enters at the top
    always_ff @(posedge axis_aclk) begin
        if (reset) begin
            window_r <= '0;
        end else if (push_s) begin
            window_r <= {push_word_s, window_r[15:1]};
        end else begin
            window_r <= window_r;
        end
    end

`ifdef MSG_SCHEDULE_PROTOCOL_CHECK_EN
    logic [1:0] sha_type_r;
    logic       err_r;

    // Sticky flag for stray tlast or a sha_type change inside a message
    always_ff @(posedge axis_aclk) begin
        if (reset) begin
            sha_type_r <= 2'b00;
            err_r      <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && s_axis_tvalid) begin
                sha_type_r <= s_axis_tuser[SHA_TUSER_OFFSET +: 2];
            end else begin
                sha_type_r <= sha_type_r;
            end
            if (in_hs_s && ((s_axis_tlast && (t_r != 7'(BLOCK_WORDS - 1))) ||
                            (s_axis_tuser[SHA_TUSER_OFFSET +: 2] != sha_type_r))) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign s_axis_tready = tready_s;
    assign m_axis_tdata  = C_M_AXIS_DATA_WIDTH'(tdata_r);
    assign m_axis_tuser  = tuser_r;
    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tlast  = tlast_r;

endmodule
